// File: rtl/xpb_table_gen.sv
// Runtime-programmable reduction table: generates T[j] = (j*C) mod M for all
// 2**IDX_W indices, then serves NUM_RD independent registered lookups.
module xpb_table_gen #(
    parameter int WORD_W = 1024,
    parameter int IDX_W  = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WORD_W-1:0]        const_in,
    input  logic [WORD_W-1:0]        mod_in,
    output logic                     busy,
    output logic                     ready,
    output logic                     err,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD*WORD_W-1:0] rd_data
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, GEN, READY} state_t;

    state_t                   state_q, state_d;
    logic [WORD_W-1:0]        c_q, c_d;
    logic [WORD_W-1:0]        m_q, m_d;
    logic [WORD_W-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]         j_q, j_d;
    logic                     busy_q, busy_d;
    logic                     ready_q, ready_d;
    logic                     err_q, err_d;
    logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
    logic [NUM_RD*WORD_W-1:0] rd_data_q, rd_data_d;
    logic [WORD_W-1:0]        tbl_q [DEPTH];
    logic [WORD_W-1:0]        tbl_d [DEPTH];

    logic [WORD_W:0]          sum;
    logic                     wrap;
    logic [WORD_W-1:0]        acc_next;
    logic                     bad_load;

    // acc < M and C < M, so acc + C < 2M and one conditional subtract is enough;
    // the subtraction fits in WORD_W bits because the result is below M.
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, c_q};
        wrap     = (sum >= {1'b0, m_q});
        acc_next = wrap ? (sum[WORD_W-1:0] - m_q) : sum[WORD_W-1:0];
        bad_load = (const_in >= mod_in) || (mod_in == '0);
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        m_d     = m_q;
        acc_d   = acc_q;
        j_d     = j_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        err_d   = err_q;
        tbl_d   = tbl_q;

        case (state_q)
            GEN: begin
                tbl_d[j_q] = acc_q;
                acc_d      = acc_next;
                j_d        = j_q + IDX_W'(1);
                if (j_q == LAST_IDX) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    c_d     = const_in;
                    m_d     = mod_in;
                    ready_d = 1'b0;
                    if (bad_load) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d    = 1'b0;
                        busy_d   = 1'b1;
                        tbl_d[0] = '0;
                        acc_d    = const_in;
                        j_d      = IDX_W'(1);
                        state_d  = GEN;
                    end
                end
            end
        endcase
    end

    // Reads sample ready_q, so a restart edge still serves the old table.
    always_comb begin
        rd_valid_d = '0;
        rd_data_d  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p] && ready_q) begin
                rd_valid_d[p]                 = 1'b1;
                rd_data_d[p*WORD_W +: WORD_W] = tbl_q[rd_idx[p*IDX_W +: IDX_W]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            c_q        <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            j_q        <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            tbl_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            m_q        <= m_d;
            acc_q      <= acc_d;
            j_q        <= j_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            tbl_q      <= tbl_d;
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Scoreboard bench for xpb_table_gen: a (j*C)%M golden model queues the
// expected outputs for every edge and they are compared one cycle later.
module tb_xpb_table_gen;
    localparam int WORD_W = 16;
    localparam int IDX_W  = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [WORD_W-1:0]        const_in;
    logic [WORD_W-1:0]        mod_in;
    logic                     busy;
    logic                     ready;
    logic                     err;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*IDX_W-1:0]  rd_idx;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD*WORD_W-1:0] rd_data;

    always #5 clk = ~clk;

    xpb_table_gen #(.WORD_W(WORD_W), .IDX_W(IDX_W), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .reset(reset), .start(start), .const_in(const_in), .mod_in(mod_in),
        .busy(busy), .ready(ready), .err(err), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        busy;
        logic        ready;
        logic        err;
    } exp_t;

    exp_t expQ[$];
    int   compCount = 0;
    int   failCount = 0;

    int          mState;
    int          mCnt;
    logic        mBusy, mReady, mErr;
    logic [15:0] mTab  [DEPTH];
    logic [15:0] mPend [DEPTH];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mCnt   = 0;
        mBusy  = 1'b0;
        mReady = 1'b0;
        mErr   = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            mTab[j]  = 16'd0;
            mPend[j] = 16'd0;
        end
    endtask

    task automatic compareNext();
        exp_t e;
        if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL queue_empty: no expectation at %0t", $time);
        end else begin
            e = expQ.pop_front();
            checkOutput("busy", 32'(busy), 32'(e.busy));
            checkOutput("ready", 32'(ready), 32'(e.ready));
            checkOutput("err", 32'(err), 32'(e.err));
            checkOutput("rd_valid", 32'(rd_valid), 32'(e.valid));
            checkOutput("rd_data0", 32'(rd_data[15:0]), 32'(e.d0));
            checkOutput("rd_data1", 32'(rd_data[31:16]), 32'(e.d1));
        end
    endtask

    // Drive one edge's inputs at the falling edge, predict, then compare.
    task automatic applyStimulus(input logic st, input logic [15:0] c, input logic [15:0] m,
                                 input logic [1:0] en, input logic [4:0] i0, input logic [4:0] i1);
        exp_t e;
        start    = st;
        const_in = c;
        mod_in   = m;
        rd_en    = en;
        rd_idx   = {i1, i0};
        e.valid[0] = en[0] & mReady;
        e.valid[1] = en[1] & mReady;
        e.d0 = e.valid[0] ? mTab[i0] : 16'd0;
        e.d1 = e.valid[1] ? mTab[i1] : 16'd0;
        if (mState == 1) begin
            mCnt++;
            if (mCnt == DEPTH - 1) begin
                mState = 2;
                mBusy  = 1'b0;
                mReady = 1'b1;
                mTab   = mPend;
            end
        end else if (st) begin
            mReady = 1'b0;
            if (c >= m || m == 16'd0) begin
                mErr   = 1'b1;
                mState = 0;
            end else begin
                mErr   = 1'b0;
                mBusy  = 1'b1;
                mState = 1;
                mCnt   = 0;
                for (int j = 0; j < DEPTH; j++)
                    mPend[j] = 16'((longint'(j) * longint'(c)) % longint'(m));
            end
        end
        e.busy  = mBusy;
        e.ready = mReady;
        e.err   = mErr;
        expQ.push_back(e);
        @(negedge clk);
        compareNext();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 5'd0, 5'd0);
    endtask

    task automatic readPair(input logic [4:0] i0, input logic [4:0] i1);
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b11, i0, i1);
    endtask

    initial begin
        logic [15:0] rc, rm;

        reset    = 1'b1;
        start    = 1'b0;
        const_in = 16'd0;
        mod_in   = 16'd0;
        rd_en    = 2'b00;
        rd_idx   = 10'd0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_rd_data", rd_data, 32'd0);
        reset = 1'b0;

        // Basic generation, reads during GEN must be invalid
        applyStimulus(1'b1, 16'd10, 16'd97, 2'b00, 5'd0, 5'd0);
        repeat (DEPTH - 1) readPair(5'd1, 5'd2);
        readPair(5'd0, 5'd1);
        readPair(5'd9, 5'd10);
        readPair(5'd31, 5'd31);
        readPair(5'd10, 5'd10);
        readPair(5'd0, 5'd31);
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b01, 5'd9, 5'd9);
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b10, 5'd9, 5'd10);

        // Rejected loads; the restart edge still serves the old table
        applyStimulus(1'b1, 16'd97, 16'd97, 2'b11, 5'd1, 5'd10);
        idleCycles(2);
        applyStimulus(1'b1, 16'd5, 16'd0, 2'b11, 5'd1, 5'd2);
        idleCycles(2);
        applyStimulus(1'b1, 16'd5, 16'd7, 2'b00, 5'd0, 5'd0);
        idleCycles(DEPTH - 1);
        readPair(5'd3, 5'd6);

        // start during GEN (cycle 7) is ignored
        applyStimulus(1'b1, 16'd10, 16'd97, 2'b00, 5'd0, 5'd0);
        idleCycles(6);
        applyStimulus(1'b1, 16'd1, 16'd3, 2'b11, 5'd3, 5'd4);
        idleCycles(DEPTH - 1 - 7);
        readPair(5'd31, 5'd10);

        // Reset in the middle of generation
        applyStimulus(1'b1, 16'd20, 16'd31, 2'b00, 5'd0, 5'd0);
        idleCycles(11);
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_ready", 32'(ready), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        checkOutput("midrst_rd_valid", 32'(rd_valid), 32'd0);
        expQ.delete();
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 16'd1, 16'd65535, 2'b11, 5'd0, 5'd1);
        idleCycles(DEPTH - 1);
        for (int j = 0; j < 16; j++) readPair(5'(j), 5'(j + 16));

        // Random loads with concurrent random reads and ignored mid-GEN starts
        for (int n = 0; n < 500; n++) begin
            rm = 16'($urandom_range(1, 65535));
            rc = 16'($urandom_range(0, 32'(rm) - 32'd1));
            applyStimulus(1'b1, rc, rm, 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            repeat (DEPTH - 1)
                applyStimulus(1'($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom),
                              2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                              5'($urandom_range(0, 31)));
            repeat (3)
                applyStimulus(1'b0, 16'd0, 16'd0, 2'($urandom_range(0, 3)),
                              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
